// File: rtl/sram_boot_loader.sv
// Byte-stream SRAM boot loader: 16-bit big-endian length header, then words written from address 0.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module sram_boot_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
        S_FIN
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              in_ready_d, mem_we_d, busy_d, done_d, err_d;
    logic              xfer;
    logic [15:0]       len_c;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_hi_q  <= 8'd0;
            remain_q  <= 16'd0;
            addr_q    <= '0;
            hi_q      <= 8'd0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            remain_q  <= remain_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            in_ready  <= in_ready_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cpu_hold  <= busy_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Next state; outputs are precomputed from the state being entered
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        remain_d    = remain_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        done_d      = done;
        err_d       = err;
        xfer        = in_valid && in_ready;
        len_c       = {len_hi_q, in_data};
`ifdef LOADER_CHECKSUM_EN
        csum_d      = xfer ? (csum_q ^ in_data) : csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LEN_HI;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    addr_d   = '0;
                    remain_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = 8'd0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    remain_d = len_c;
                    if (len_c == 16'd0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (32'(len_c) > DEPTH) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
            end
            S_DAT_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (xfer) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = DATA_W'({hi_q, in_data});
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - 16'd1;
                if (remain_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_FIN;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_DAT_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_FIN;
                    if (in_data == csum_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DAT_HI) || (state_d == S_DAT_LO);
`ifdef LOADER_CHECKSUM_EN
        if (state_d == S_CSUM) in_ready_d = 1'b1;
`endif
        mem_we_d = (state_d == S_WRITE);
        busy_d   = (state_d != S_IDLE) && (state_d != S_FIN);
    end

endmodule

// File: tb/tb_sram_boot_loader.sv
// Randomized self-checking bench for sram_boot_loader against a stream-level reference model.
module tb_sram_boot_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready, mem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sram [DEPTH];
    int          we_cnt;
    logic [7:0]  stream[$];
    logic [15:0] exp_words[$];

    always #5 clk = ~clk;

    sram_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    // SRAM behavioural model fed by the write port
    always @(negedge clk) begin
        if (mem_we) begin
            sram[mem_addr] = mem_wdata;
            we_cnt = we_cnt + 1;
        end
    end

    task automatic clear_sram();
        for (int i = 0; i < DEPTH; i++) sram[i] = 16'hDEAD;
        we_cnt = 0;
    endtask

    task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'd0;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(x);
`endif
    endtask

    // Stream for an N-word session with random payload; expected words recorded alongside
    task automatic build(input int n);
        logic [15:0] w;
        stream = {};
        exp_words = {};
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                exp_words.push_back(w);
                stream.push_back(w[15:8]);
                stream.push_back(w[7:0]);
            end
            add_csum();
        end
    endtask

    // Offer the stream; returns on the negedge just after the last byte is accepted
    task automatic drive(input bit do_start, input int gap_pct, input int stall_idx,
                         input int stall_len, input bit poke_start);
        int  i = 0;
        int  cyc = 0;
        int  stall_left = stall_len;
        bit  x;
        if (do_start) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        while (i < stream.size() && cyc < 40000) begin
            start = 1'b0;
            if (i == stall_idx && stall_left > 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                start    = poke_start && (stall_left == 3);
                stall_left--;
            end else if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = stream[i];
            end
            x = in_valid && in_ready;
            @(posedge clk);
            if (x) i++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (i != stream.size()) begin
            n_fail++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, stream.size());
        end
    endtask

    task automatic wait_end();
        int c = 0;
        while (!(done || err) && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (!(done || err)) begin
            n_fail++;
            $display("FAIL end_timeout: done=%0b err=%0b after %0d cycles", done, err, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {in_ready, mem_we, cpu_hold, busy, done, err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_sram();
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        add_csum();
        drive(1'b1, 0, -1, 0, 1'b0);
        wait_end();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sram[0] !== 16'h1234 || sram[1] !== 16'hABCD) begin
            n_fail++;
            $display("FAIL basic_data: mem0=%h mem1=%h, required 1234 abcd", sram[0], sram[1]);
        end
        n_checks++;
        if (we_cnt !== 2) begin
            n_fail++;
            $display("FAIL basic_we_count: got %0d, required 2", we_cnt);
        end
        n_checks++;
        if ({done, err, cpu_hold, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_status: done/err/hold/busy=%b, required 1000",
                     {done, err, cpu_hold, busy});
        end
    endtask

    task automatic test_zero_len();
        clear_sram();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if ({busy, cpu_hold, in_ready, done} !== 4'b1110) begin
            n_fail++;
            $display("FAIL start_status: busy/hold/ready/done=%b, required 1110",
                     {busy, cpu_hold, in_ready, done});
        end
        stream = '{8'h00, 8'h00};
        drive(1'b0, 0, -1, 0, 1'b0);
        n_checks++;
        if ({done, err, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_len_timing: done/err/busy=%b one cycle after LEN_LO, required 100",
                     {done, err, busy});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (we_cnt !== 0) begin
            n_fail++;
            $display("FAIL zero_len_we: got %0d writes, required 0", we_cnt);
        end
    endtask

    task automatic test_length_limits();
        int n;
        int bad;
        for (int k = 0; k < 2; k++) begin
            n = DEPTH + k;
            clear_sram();
            build(n);
            drive(1'b1, 0, -1, 0, 1'b0);
            wait_end();
            repeat (2) @(negedge clk);
            n_checks++;
            if (done !== (n <= DEPTH) || err !== (n > DEPTH)) begin
                n_fail++;
                $display("FAIL len_%0d_status: done=%0b err=%0b, required %0b %0b",
                         n, done, err, n <= DEPTH, n > DEPTH);
            end
            n_checks++;
            if (we_cnt !== ((n <= DEPTH) ? n : 0)) begin
                n_fail++;
                $display("FAIL len_%0d_we: got %0d writes", n, we_cnt);
            end
            bad = 0;
            for (int i = 0; i < exp_words.size(); i++) if (sram[i] !== exp_words[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL len_%0d_data: %0d words differ, required 0", n, bad);
            end
        end
    endtask

    task automatic test_stall();
        clear_sram();
        build(3);
        drive(1'b1, 0, 5, 5, 1'b1);
        wait_end();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sram[0] !== exp_words[0] || sram[1] !== exp_words[1] || sram[2] !== exp_words[2]) begin
            n_fail++;
            $display("FAIL stall_data: %h %h %h, required %h %h %h",
                     sram[0], sram[1], sram[2], exp_words[0], exp_words[1], exp_words[2]);
        end
        n_checks++;
        if (we_cnt !== 3 || sram[3] !== 16'hDEAD) begin
            n_fail++;
            $display("FAIL stall_we: count=%0d mem3=%h, required 3 dead", we_cnt, sram[3]);
        end
        n_checks++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_status: done/err=%b, required 10", {done, err});
        end
    endtask

    task automatic test_random();
        int n;
        int bad;
        for (int s = 0; s < 6; s++) begin
            n = int'($urandom_range(1, 10));
            clear_sram();
            build(n);
            drive(1'b1, 40, -1, 0, 1'b0);
            wait_end();
            repeat (2) @(negedge clk);
            bad = 0;
            for (int i = 0; i < n; i++) if (sram[i] !== exp_words[i]) bad++;
            n_checks++;
            if (bad != 0 || sram[n] !== 16'hDEAD) begin
                n_fail++;
                $display("FAIL random_%0d_data: %0d words differ, mem[N]=%h", s, bad, sram[n]);
            end
            n_checks++;
            if (we_cnt !== n) begin
                n_fail++;
                $display("FAIL random_%0d_we: got %0d, required %0d", s, we_cnt, n);
            end
            n_checks++;
            if ({done, err, cpu_hold} !== 3'b100) begin
                n_fail++;
                $display("FAIL random_%0d_status: done/err/hold=%b, required 100",
                         s, {done, err, cpu_hold});
            end
        end
    endtask

    task automatic test_reset_mid();
        int  i = 0;
        int  c = 0;
        bit  seen = 1'b0;
        bit  x;
        clear_sram();
        build(4);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!seen && c < 100) begin
            in_valid = 1'b1;
            in_data  = stream[i];
            x = in_ready;
            @(posedge clk);
            if (x) i++;
            @(negedge clk);
            c++;
            if (mem_we) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid_first_write: no mem_we within %0d cycles", c);
        end
        in_data = stream[i];
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b, required 000000",
                     {in_ready, mem_we, cpu_hold, busy, done, err});
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (we_cnt !== 1 || sram[0] !== exp_words[0] ||
            sram[1] !== 16'hDEAD || sram[2] !== 16'hDEAD || sram[3] !== 16'hDEAD) begin
            n_fail++;
            $display("FAIL reset_mid_mem: we=%0d mem0..3=%h %h %h %h, required 1 %h dead dead dead",
                     we_cnt, sram[0], sram[1], sram[2], sram[3], exp_words[0]);
        end
        stream = '{8'h00, 8'h01, 8'hFF, 8'hFF};
        add_csum();
        drive(1'b1, 0, -1, 0, 1'b0);
        wait_end();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sram[0] !== 16'hFFFF || {done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_reload: mem0=%h done/err=%b, required ffff 10",
                     sram[0], {done, err});
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            clear_sram();
            stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
            if (k == 1) stream[4] = 8'h00;
            drive(1'b1, 0, -1, 0, 1'b0);
            wait_end();
            repeat (2) @(negedge clk);
            n_checks++;
            if ({done, err} !== ((k == 0) ? 2'b10 : 2'b01) || sram[0] !== 16'h1234) begin
                n_fail++;
                $display("FAIL checksum_%0d: done/err=%b mem0=%h", k, {done, err}, sram[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_random();
        test_length_limits();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
